dcache_assoc: RTL and testbench
===============================

# dcache_assoc

Parametrised write-back, write-allocate, N-way set-associative data cache with LRU replacement, sitting between the datapath's data-memory port and the memory controller's data port. It generalises the 2-way, 8-set, 2-word-block data cache to configurable sets, ways and block size. On `halt` it flushes every dirty line to memory, optionally writes the hit count to a fixed address, then raises `flushed`.

## Interface
- `SETS`, 8: number of sets; power of 2, 2..64.
- `WAYS`, 2: associativity; power of 2, 1..4.
- `BLK_WORDS`, 2: 32-bit words per block; power of 2, 1..8.
- `HITCNT_ADDR`, 32'h0000_3100: word address for the hit-count write during flush.
- `CLK` input 1: clock; all state updates on the rising edge.
- `RST` input 1: synchronous, active-high reset.
- `dmemREN` input 1: datapath read request.
- `dmemWEN` input 1: datapath write request; if both requests are high, the request is treated as a write.
- `dmemaddr` input 32: byte address. Fields: [1:0] byte offset (ignored), then word offset of log2(BLK_WORDS) bits, then index of log2(SETS) bits, then tag from the remaining bits.
- `dmemstore` input 32: write data.
- `halt` input 1: start the flush.
- `dmemload` output 32: read data; 0 when `dhit` is 0.
- `dhit` output 1: request complete this cycle.
- `flushed` output 1: flush finished.
- `dREN`, `dWEN` output 1: memory read and write strobes.
- `daddr` output 32: memory word address; [1:0] = 00.
- `dstore` output 32: memory write data.
- `dload` input 32: memory read data.
- `dwait` input 1: memory busy; a memory transfer completes on a cycle with `dwait`=0.

## Operation
- Storage per line: `valid`, `dirty`, tag, and BLK_WORDS data words. Per set: one log2(WAYS)-bit age per way. Age 0 means most recently used; the ages in a set always form a permutation.
- Reset:
  - All lines are invalid and clean.
  - Ages in each set are initialised to the way numbers.
  - Counters are 0 and the state is IDLE.
  - All outputs are 0.
- States: IDLE, WB, FETCH, FLUSH, HITCNT, DONE.
- IDLE, `halt`=1: go to FLUSH. Halt has priority over a pending request.
- IDLE, request that hits:
  - `dhit`=1 in the same cycle (combinational).
  - Read: `dmemload` = the addressed word.
  - Write: the word is updated and `dirty` is set at the clock edge.
  - The hit way's age becomes 0; ways younger than it age by 1.
- IDLE, request that misses:
  - Victim = lowest-numbered invalid way; otherwise the way with age WAYS-1.
  - Victim valid and dirty: go to WB. Otherwise go to FETCH.
- WB:
  - `dWEN`=1; `daddr` = {victim tag, index, k, 00}; `dstore` = victim word k, with k from 0 to BLK_WORDS-1.
  - k advances when `dwait`=0. After the last word, clear `dirty` and go to FETCH.
- FETCH:
  - `dREN`=1; `daddr` = {request tag, index, k, 00}.
  - `dload` is written into victim word k when `dwait`=0.
  - After the last word: set `valid`, set the tag, clear `dirty`, set the `refill` flag, and return to IDLE. The request then hits on the following cycle.
- Hit counter, 32-bit, wrapping:
  - Increments on each `dhit` cycle while `refill`=0.
  - `refill` clears on any `dhit` cycle.
- FLUSH:
  - Visits every (set, way, word) in set-major, then way, then word order.
  - Valid and dirty line: issue `dWEN`, `daddr` = {tag, set, word, 00}, `dstore` = data; advance when `dwait`=0.
  - Other lines: skipped, one cycle each, with `dWEN`=0.
  - Afterwards all `dirty` bits are 0; go to HITCNT, or to DONE without the feature (see Configuration).
- HITCNT: `dWEN`=1, `daddr`=HITCNT_ADDR, `dstore`=hit count; on `dwait`=0 go to DONE.
- DONE: `flushed`=1 and held until reset. All requests are ignored and `dhit`=0.
- Requests arriving outside IDLE get `dhit`=0 and are held by the datapath.
- `RST` in any state, including mid-WB or mid-FETCH: the next cycle is the reset state. Partial fills are discarded and strobes drop.

## Timing
- Hit latency: 0 cycles (`dhit` is combinational).
- Clean miss: 1 IDLE cycle + BLK_WORDS transfers + 1 IDLE hit cycle. Minimum BLK_WORDS+2 cycles with `dwait` low.
- Dirty miss: adds BLK_WORDS write transfers.
- Flush: SETS·WAYS·BLK_WORDS cycles plus one extra cycle per dirty-word `dwait` stall, + HITCNT transfer + 1 cycle to `flushed`.
- Memory strobes are combinational from state. `daddr` is stable while `dwait`=1.

## Configuration
- `DCACHE_HITCNT_EN`:
  - Defined: the hit counter, `refill` flag and HITCNT state are compiled in.
  - Undefined: no counter and no HITCNT state; FLUSH goes directly to DONE and HITCNT_ADDR is unused.

## Test plan
All scenarios use SETS=8, WAYS=2, BLK_WORDS=2 unless noted; `dwait` is high 2 cycles per transfer.
- Cold read of 0x40 → `dREN` at 0x40, then 0x44; `dhit` with `dmemload` = mem[0x40]. Read of 0x44 then hits in 0 cycles with no `dREN`.
- Write 0xDEADBEEF to 0x40 after fill → `dhit` in the same cycle; a read of 0x40 returns 0xDEADBEEF; no memory traffic.
- Set-0 conflict: write 0x40, read 0x80, read 0xC0 → `dWEN` 0x40 (0xDEADBEEF), then 0x44, then `dREN` 0xC0/0xC4. Way 1 (0x80) is retained.
- Flush with dirty lines at set 0 way 0 and set 3 way 1 → `dWEN` only for 0x40, 0x44, 0x98, 0x9C in that order, then HITCNT_ADDR with the hit count; `flushed`=1 held.
- `RST` asserted mid-FETCH → next cycle `dREN`=0 and `dhit`=0; a re-read of the same address misses again.
- WAYS=4: fill 4 ways of set 0, then touch way 0 → the next miss evicts way 1. With `DCACHE_HITCNT_EN` undefined, flush ends with no write to 0x3100.

Source files
------------

// File: rtl/dcache_assoc.sv
// dcache_assoc: write-back, write-allocate, N-way set-associative data cache with
// LRU replacement between the datapath data port and the memory data port.
// On halt every dirty line is written back, then (optionally) the hit count is
// written to HITCNT_ADDR, then flushed is raised and held until reset.
//
// Optional feature macro: DCACHE_HITCNT_EN (hit counter, refill flag, HITCNT state).
//
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   dmemREN/dmemWEN       datapath read/write request (write wins when both set)
//   dmemaddr, dmemstore   byte address and write data
//   halt                  start the flush
//   dmemload, dhit        read data (0 unless dhit) and request-complete strobe
//   flushed               flush finished
//   dREN, dWEN, daddr     memory strobes and word address
//   dstore, dload, dwait  memory write data, read data, busy
module dcache_assoc #(
  parameter int unsigned SETS        = 8,
  parameter int unsigned WAYS        = 2,
  parameter int unsigned BLK_WORDS   = 2,
  parameter logic [31:0] HITCNT_ADDR = 32'h0000_3100
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  input  logic        halt,
  output logic [31:0] dmemload,
  output logic        dhit,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic [31:0] dload,
  input  logic        dwait
);

  localparam int unsigned WordBits = $clog2(BLK_WORDS);
  localparam int unsigned IdxBits  = $clog2(SETS);
  localparam int unsigned TagBits  = 30 - WordBits - IdxBits;
  localparam int unsigned WcBits   = (WordBits > 0) ? WordBits : 1;
  localparam int unsigned AgeBits  = (WAYS > 1) ? $clog2(WAYS) : 1;

`ifdef DCACHE_HITCNT_EN
  typedef enum logic [2:0] {StIdle, StWb, StFetch, StFlush, StHitcnt, StDone} state_e;
`else
  typedef enum logic [2:0] {StIdle, StWb, StFetch, StFlush, StDone} state_e;
`endif

  state_e state_q, state_d;
  logic [WcBits-1:0]  k_q, k_d;
  logic [AgeBits-1:0] victim_q, victim_d;
  logic [IdxBits-1:0] fs_q, fs_d;
  logic [AgeBits-1:0] fw_q, fw_d;

  logic               valid_q [SETS][WAYS];
  logic               dirty_q [SETS][WAYS];
  logic [AgeBits-1:0] age_q   [SETS][WAYS];
  logic [TagBits-1:0] tag_q   [SETS][WAYS];
  logic [31:0]        data_q  [SETS][WAYS][BLK_WORDS];

  logic [TagBits-1:0] req_tag;
  logic [IdxBits-1:0] req_idx;
  logic [WcBits-1:0]  req_word;
  logic               hit;
  logic [AgeBits-1:0] hit_way, hit_age, vic_way;
  logic               lru_upd, hit_wr, wb_done, fill_wr, fill_done, flush_clr, adv;

  assign req_tag  = dmemaddr[31 -: TagBits];
  assign req_idx  = dmemaddr[2+WordBits +: IdxBits];
  assign req_word = WcBits'(dmemaddr[31:2] & 30'(BLK_WORDS - 1));

  function automatic logic [31:0] mk_addr(input logic [TagBits-1:0] tag,
                                          input logic [IdxBits-1:0] idx,
                                          input logic [WcBits-1:0]  word);
    mk_addr = (32'(tag) << (2 + WordBits + IdxBits)) | (32'(idx) << (2 + WordBits)) |
              (32'(word) << 2);
  endfunction

  // Tag match and victim choice for the addressed set.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    vic_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = AgeBits'(w);
      end
      if (age_q[req_idx][w] == AgeBits'(WAYS - 1)) vic_way = AgeBits'(w);
    end
    // Lowest-numbered invalid way overrides the LRU choice.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[req_idx][w]) vic_way = AgeBits'(w);
    end
    hit_age = age_q[req_idx][hit_way];
  end

`ifdef DCACHE_HITCNT_EN
  logic [31:0] hitcnt_q;
  logic        refill_q;
  logic        unused_bits;
  assign unused_bits = ^dmemaddr[1:0];
`else
  logic unused_bits;
  assign unused_bits = ^{dmemaddr[1:0], HITCNT_ADDR};
`endif

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    victim_d  = victim_q;
    fs_d      = fs_q;
    fw_d      = fw_q;
    dhit      = 1'b0;
    dmemload  = '0;
    flushed   = 1'b0;
    dREN      = 1'b0;
    dWEN      = 1'b0;
    daddr     = '0;
    dstore    = '0;
    lru_upd   = 1'b0;
    hit_wr    = 1'b0;
    wb_done   = 1'b0;
    fill_wr   = 1'b0;
    fill_done = 1'b0;
    flush_clr = 1'b0;
    adv       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (halt) begin
          state_d = StFlush;
          k_d     = '0;
          fs_d    = '0;
          fw_d    = '0;
        end else if (dmemREN || dmemWEN) begin
          if (hit) begin
            dhit     = 1'b1;
            dmemload = data_q[req_idx][hit_way][req_word];
            lru_upd  = 1'b1;
            hit_wr   = dmemWEN;
          end else begin
            victim_d = vic_way;
            k_d      = '0;
            state_d  = (valid_q[req_idx][vic_way] && dirty_q[req_idx][vic_way]) ? StWb
                                                                                 : StFetch;
          end
        end
      end
      StWb: begin
        dWEN   = 1'b1;
        daddr  = mk_addr(tag_q[req_idx][victim_q], req_idx, k_q);
        dstore = data_q[req_idx][victim_q][k_q];
        if (!dwait) begin
          if (k_q == WcBits'(BLK_WORDS - 1)) begin
            k_d     = '0;
            wb_done = 1'b1;
            state_d = StFetch;
          end else begin
            k_d = k_q + WcBits'(1);
          end
        end
      end
      StFetch: begin
        dREN  = 1'b1;
        daddr = mk_addr(req_tag, req_idx, k_q);
        if (!dwait) begin
          fill_wr = 1'b1;
          if (k_q == WcBits'(BLK_WORDS - 1)) begin
            k_d       = '0;
            fill_done = 1'b1;
            state_d   = StIdle;
          end else begin
            k_d = k_q + WcBits'(1);
          end
        end
      end
      StFlush: begin
        if (valid_q[fs_q][fw_q] && dirty_q[fs_q][fw_q]) begin
          dWEN   = 1'b1;
          daddr  = mk_addr(tag_q[fs_q][fw_q], fs_q, k_q);
          dstore = data_q[fs_q][fw_q][k_q];
          adv    = !dwait;
        end else begin
          adv = 1'b1;
        end
        if (adv) begin
          if (k_q == WcBits'(BLK_WORDS - 1)) begin
            k_d       = '0;
            flush_clr = 1'b1;
            if (fw_q == AgeBits'(WAYS - 1)) begin
              fw_d = '0;
              if (fs_q == IdxBits'(SETS - 1)) begin
`ifdef DCACHE_HITCNT_EN
                state_d = StHitcnt;
`else
                state_d = StDone;
`endif
              end else begin
                fs_d = fs_q + IdxBits'(1);
              end
            end else begin
              fw_d = fw_q + AgeBits'(1);
            end
          end else begin
            k_d = k_q + WcBits'(1);
          end
        end
      end
`ifdef DCACHE_HITCNT_EN
      StHitcnt: begin
        dWEN   = 1'b1;
        daddr  = HITCNT_ADDR;
        dstore = hitcnt_q;
        if (!dwait) state_d = StDone;
      end
`endif
      StDone: flushed = 1'b1;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      k_q      <= '0;
      victim_q <= '0;
      fs_q     <= '0;
      fw_q     <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          age_q[s][w]   <= AgeBits'(w);
        end
      end
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      victim_q <= victim_d;
      fs_q     <= fs_d;
      fw_q     <= fw_d;
      if (lru_upd) begin
        for (int w = 0; w < WAYS; w++) begin
          if (age_q[req_idx][w] < hit_age) age_q[req_idx][w] <= age_q[req_idx][w] + AgeBits'(1);
        end
        age_q[req_idx][hit_way] <= '0;
      end
      if (hit_wr)    dirty_q[req_idx][hit_way]  <= 1'b1;
      if (wb_done)   dirty_q[req_idx][victim_q] <= 1'b0;
      if (flush_clr) dirty_q[fs_q][fw_q]        <= 1'b0;
      if (fill_done) begin
        valid_q[req_idx][victim_q] <= 1'b1;
        dirty_q[req_idx][victim_q] <= 1'b0;
      end
    end
  end

`ifdef DCACHE_HITCNT_EN
  // The hit that completes a refilled miss is not counted as a hit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hitcnt_q <= '0;
      refill_q <= 1'b0;
    end else begin
      if (dhit) begin
        if (!refill_q) hitcnt_q <= hitcnt_q + 32'd1;
        refill_q <= 1'b0;
      end
      if (fill_done) refill_q <= 1'b1;
    end
  end
`endif

  // Data and tags need no reset: valid bits gate every use.
  always_ff @(posedge CLK) begin
    if (hit_wr)    data_q[req_idx][hit_way][req_word] <= dmemstore;
    if (fill_wr)   data_q[req_idx][victim_q][k_q]     <= dload;
    if (fill_done) tag_q[req_idx][victim_q]           <= req_tag;
  end

endmodule

// File: tb/tb_dcache_assoc.sv
// Bench for dcache_assoc: instance A (8 sets, 2 ways, 2 words) and instance B
// (8 sets, 4 ways, 2 words), each with its own memory responder that holds dwait
// high for 2 cycles per transfer. Expected hits and memory transfers go into a
// scoreboard queue; a negedge monitor pops and compares them as they appear.
module tb_dcache_assoc;
  localparam int KHit = 0, KRd = 1, KWr = 2, KFl = 3;

  typedef struct {
    int          dut;
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
    bit          dchk;
  } ev_t;

  ev_t sbq[$];
  int  n_vec = 0;
  int  n_err = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst[2], ren[2], wen[2], hlt[2];
  logic        dhit[2], flushed[2], dren[2], dwen[2], dwait[2], fl_prev[2];
  logic [31:0] addr[2], store[2], load[2], daddr[2], dstore[2], dload[2];
  int          cnt[2];

  function automatic logic [31:0] memfn(input logic [31:0] a);
    memfn = 32'hA500_0000 | a;
  endfunction

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      dwait[d] = (cnt[d] < 2);
      dload[d] = memfn(daddr[d]);
    end
  end

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if ((dren[d] || dwen[d]) && dwait[d]) cnt[d] <= cnt[d] + 1;
      else cnt[d] <= 0;
    end
  end

  dcache_assoc #(.SETS(8), .WAYS(2), .BLK_WORDS(2), .HITCNT_ADDR(32'h0000_3100)) u_dut_a (
    .CLK(clk), .RST(rst[0]), .dmemREN(ren[0]), .dmemWEN(wen[0]), .dmemaddr(addr[0]),
    .dmemstore(store[0]), .halt(hlt[0]), .dmemload(load[0]), .dhit(dhit[0]),
    .flushed(flushed[0]), .dREN(dren[0]), .dWEN(dwen[0]), .daddr(daddr[0]),
    .dstore(dstore[0]), .dload(dload[0]), .dwait(dwait[0])
  );

  dcache_assoc #(.SETS(8), .WAYS(4), .BLK_WORDS(2), .HITCNT_ADDR(32'h0000_3100)) u_dut_b (
    .CLK(clk), .RST(rst[1]), .dmemREN(ren[1]), .dmemWEN(wen[1]), .dmemaddr(addr[1]),
    .dmemstore(store[1]), .halt(hlt[1]), .dmemload(load[1]), .dhit(dhit[1]),
    .flushed(flushed[1]), .dREN(dren[1]), .dWEN(dwen[1]), .daddr(daddr[1]),
    .dstore(dstore[1]), .dload(dload[1]), .dwait(dwait[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic push(input int d, input int k, input logic [31:0] a, input logic [31:0] v,
                      input bit c);
    ev_t e;
    e.dut = d; e.kind = k; e.addr = a; e.data = v; e.dchk = c;
    sbq.push_back(e);
  endtask

  task automatic pop_chk(input int d, input int k, input logic [31:0] a, input logic [31:0] v);
    ev_t e;
    if (sbq.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL sb_unexpected: dut %0d kind %0d addr %h data %h seen, nothing required",
               d, k, a, v);
      return;
    end
    e = sbq.pop_front();
    chk("sb_dut", d, e.dut);
    chk("sb_kind", k, e.kind);
    chk("sb_addr", a, e.addr);
    if (e.dchk) chk("sb_data", v, e.data);
  endtask

  // Monitor: every hit, completed memory transfer and flushed edge consumes an entry.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (dhit[d]) pop_chk(d, KHit, 32'h0, load[d]);
      else chk("dmemload_zero_without_hit", load[d], 32'h0);
      if ((dren[d] || dwen[d]) && !dwait[d]) pop_chk(d, dren[d] ? KRd : KWr, daddr[d], dstore[d]);
      if (flushed[d] && !fl_prev[d]) pop_chk(d, KFl, 32'h0, 32'h0);
      fl_prev[d] <= flushed[d];
    end
  end

  task automatic req(input int d, input bit we, input logic [31:0] a, input logic [31:0] v,
                     output int n);
    n = 0;
    addr[d] = a; store[d] = v; ren[d] = !we; wen[d] = we;
    do begin
      @(negedge clk);
      n++;
    end while (!dhit[d] && n < 200);
    if (!dhit[d]) begin
      n_vec++;
      n_err++;
      $display("FAIL req_timeout: dut %0d addr %h got no dhit, dhit required", d, a);
    end
    @(posedge clk);
    #1;
    ren[d] = 1'b0; wen[d] = 1'b0;
  endtask

  task automatic miss_rd(input int d, input logic [31:0] a);
    int n;
    push(d, KRd, {a[31:3], 3'b000}, 32'h0, 1'b0);
    push(d, KRd, {a[31:3], 3'b100}, 32'h0, 1'b0);
    push(d, KHit, 32'h0, memfn(a), 1'b1);
    req(d, 1'b0, a, 32'h0, n);
  endtask

  task automatic hit_rd(input int d, input logic [31:0] a, input logic [31:0] v);
    int n;
    push(d, KHit, 32'h0, v, 1'b1);
    req(d, 1'b0, a, 32'h0, n);
    chk("hit_latency", n, 1);
  endtask

  task automatic wr(input int d, input logic [31:0] a, input logic [31:0] v, input bit miss);
    int n;
    if (miss) begin
      push(d, KRd, {a[31:3], 3'b000}, 32'h0, 1'b0);
      push(d, KRd, {a[31:3], 3'b100}, 32'h0, 1'b0);
    end
    push(d, KHit, 32'h0, 32'h0, 1'b0);
    req(d, 1'b1, a, v, n);
    if (!miss) chk("write_hit_latency", n, 1);
  endtask

  task automatic do_halt(input int d);
    int n = 0;
    hlt[d] = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!flushed[d] && n < 1000);
    if (!flushed[d]) begin
      n_vec++;
      n_err++;
      $display("FAIL flush_timeout: dut %0d flushed=0, flushed=1 required", d);
    end
    addr[d] = 32'h40; ren[d] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("flushed_held", flushed[d], 1);
      chk("done_no_hit", dhit[d], 0);
    end
    @(posedge clk);
    #1;
    ren[d] = 1'b0; hlt[d] = 1'b0;
  endtask

  initial begin
    int n;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; ren[d] = 1'b0; wen[d] = 1'b0; hlt[d] = 1'b0;
      addr[d] = 32'h0; store[d] = 32'h0; fl_prev[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_ctl", {28'h0, dhit[d], flushed[d], dren[d], dwen[d]}, 32'h0);
      chk("rst_daddr", daddr[d], 32'h0);
      chk("rst_dstore", dstore[d], 32'h0);
      chk("rst_dmemload", load[d], 32'h0);
    end
    rst[0] = 1'b0; rst[1] = 1'b0;

    // A: cold read, hit on neighbour word, write hit, read-back.
    miss_rd(0, 32'h40);
    hit_rd(0, 32'h44, 32'hA500_0044);
    wr(0, 32'h40, 32'hDEAD_BEEF, 1'b0);
    hit_rd(0, 32'h40, 32'hDEAD_BEEF);
    // A: set-0 conflict; dirty way 0 is the LRU victim, way 1 (0x80) stays.
    wr(0, 32'h40, 32'hDEAD_BEEF, 1'b0);
    miss_rd(0, 32'h80);
    push(0, KWr, 32'h40, 32'hDEAD_BEEF, 1'b1);
    push(0, KWr, 32'h44, 32'hA500_0044, 1'b1);
    miss_rd(0, 32'hC0);
    hit_rd(0, 32'h80, 32'hA500_0080);

    // A: reset in the middle of a fetch.
    addr[0] = 32'h100; ren[0] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dren[0] && n < 20);
    chk("fetch_started", dren[0], 1);
    @(posedge clk);
    #1;
    rst[0] = 1'b1;
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    chk("rst_mid_fetch_dREN", dren[0], 0);
    chk("rst_mid_fetch_dhit", dhit[0], 0);
    ren[0] = 1'b0;
    miss_rd(0, 32'h100);

    // A: fresh cache, dirty lines at set 0 way 0 and set 3 way 1, two counted hits.
    rst[0] = 1'b1;
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    wr(0, 32'h40, 32'h1111_2222, 1'b1);
    hit_rd(0, 32'h40, 32'h1111_2222);
    miss_rd(0, 32'h18);
    wr(0, 32'h98, 32'h3333_4444, 1'b1);
    hit_rd(0, 32'h44, 32'hA500_0044);
    push(0, KWr, 32'h40, 32'h1111_2222, 1'b1);
    push(0, KWr, 32'h44, 32'hA500_0044, 1'b1);
    push(0, KWr, 32'h98, 32'h3333_4444, 1'b1);
    push(0, KWr, 32'h9C, 32'hA500_009C, 1'b1);
`ifdef DCACHE_HITCNT_EN
    push(0, KWr, 32'h3100, 32'd2, 1'b1);
`endif
    push(0, KFl, 32'h0, 32'h0, 1'b0);
    do_halt(0);

    // B: fill four ways of set 0, touch way 0, next miss must evict way 1 (0x80).
    miss_rd(1, 32'h40);
    miss_rd(1, 32'h80);
    miss_rd(1, 32'hC0);
    miss_rd(1, 32'h100);
    hit_rd(1, 32'h40, 32'hA500_0040);
    miss_rd(1, 32'h140);
    hit_rd(1, 32'h40, 32'hA500_0040);
    hit_rd(1, 32'hC0, 32'hA500_00C0);
    hit_rd(1, 32'h100, 32'hA500_0100);
    miss_rd(1, 32'h80);
`ifdef DCACHE_HITCNT_EN
    push(1, KWr, 32'h3100, 32'd4, 1'b1);
`endif
    push(1, KFl, 32'h0, 32'h0, 1'b0);
    do_halt(1);

    repeat (3) @(posedge clk);
    chk("sb_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, completion required");
    $fatal(1, "watchdog");
  end

endmodule
